fifo_status: RTL and testbench

//   Parametrised synchronous show-ahead FIFO. Successor to the 8x8 minilab FIFO.

---
 rtl/fifo_status.sv | 128 ++++++++++++
 tb/tb_fifo_status.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_status.sv
// Synchronous show-ahead FIFO with occupancy level, almost-full/almost-empty thresholds
// and sticky overflow/underflow error flags. Any DEPTH >= 2; pointers wrap explicitly.
module fifo_status #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wren,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          rden,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    input  logic                          clr_err,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rd_ok, wr_ok;

    // Pointer increment with explicit wrap so non-power-of-2 depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ok   = rden & ~empty_q;
        wr_ok   = wren & (~full_q | rden);
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (rd_ok) begin
            head_d = ptr_inc(head_q);
        end
        if (wr_ok) begin
            tail_d = ptr_inc(tail_q);
        end
        if (wr_ok && !rd_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - LVL_W'(1);
        end

        // A new error event in the same cycle as clr_err keeps the flag set.
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wren && full_q && !rden) begin
            ovf_d = 1'b1;
        end
        if (rden && empty_q) begin
            udf_d = 1'b1;
        end

        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
        af_d    = (level_d >= LVL_W'(AF_LEVEL));
        ae_d    = (level_d <= LVL_W'(AE_LEVEL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[tail_q] <= i_data;
        end
    end

    assign o_data       = empty_q ? '0 : mem_q[head_q];
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_status.sv
// Directed bench for fifo_status: an 8-deep instance for fill/drain/error cases and a
// 5-deep instance for pointer wrap.
module tb_fifo_status;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 8-deep instance
    logic       rst8, wren8, rden8, clr8;
    logic [7:0] din8, dout8;
    logic       full8, empty8, af8, ae8, ovf8, udf8;
    logic [3:0] lvl8;

    fifo_status #(.DEPTH(8), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u8 (
        .clk(clk), .rst(rst8), .wren(wren8), .i_data(din8), .rden(rden8),
        .o_data(dout8), .full(full8), .empty(empty8), .almost_full(af8),
        .almost_empty(ae8), .level(lvl8), .clr_err(clr8),
        .overflow(ovf8), .underflow(udf8)
    );

    // 5-deep instance
    logic       rst5, wren5, rden5, clr5;
    logic [7:0] din5, dout5;
    logic       full5, empty5, af5, ae5, ovf5, udf5;
    logic [2:0] lvl5;

    fifo_status #(.DEPTH(5), .DATA_WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1)) u5 (
        .clk(clk), .rst(rst5), .wren(wren5), .i_data(din5), .rden(rden5),
        .o_data(dout5), .full(full5), .empty(empty5), .almost_full(af5),
        .almost_empty(ae5), .level(lvl5), .clr_err(clr5),
        .overflow(ovf5), .underflow(udf5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock on the 8-deep FIFO; outputs are sampled 1ns after the edge.
    task automatic cyc8(input logic w, input logic r, input logic [7:0] d, input logic c);
        wren8 = w; rden8 = r; din8 = d; clr8 = c;
        @(posedge clk);
        #1;
        wren8 = 1'b0; rden8 = 1'b0; clr8 = 1'b0;
    endtask

    task automatic cyc5(input logic w, input logic r, input logic [7:0] d);
        wren5 = w; rden5 = r; din5 = d;
        @(posedge clk);
        #1;
        wren5 = 1'b0; rden5 = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        rst8 = 1'b1; wren8 = 1'b1; rden8 = 1'b0; din8 = 8'hEE; clr8 = 1'b0;
        rst5 = 1'b1; wren5 = 1'b1; rden5 = 1'b0; din5 = 8'hEE; clr5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(lvl8), 32'd0);
        chk("rst_empty", 32'(empty8), 32'd1);
        chk("rst_ae", 32'(ae8), 32'd1);
        chk("rst_full", 32'(full8), 32'd0);
        chk("rst_af", 32'(af8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_udf", 32'(udf8), 32'd0);
        chk("rst5_level", 32'(lvl5), 32'd0);
        rst8 = 1'b0; wren8 = 1'b0; rst5 = 1'b0; wren5 = 1'b0;
        cyc8(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_level", 32'(lvl8), 32'd0);
        chk("post_rst_odata", 32'(dout8), 32'd0);

        // Fill 01..08
        for (int i = 1; i <= 8; i++) begin
            cyc8(1'b1, 1'b0, 8'(i), 1'b0);
            chk("fill_level", 32'(lvl8), 32'(i));
            chk("fill_full", 32'(full8), (i == 8) ? 32'd1 : 32'd0);
            chk("fill_af", 32'(af8), (i >= 6) ? 32'd1 : 32'd0);
            chk("fill_ae", 32'(ae8), (i <= 2) ? 32'd1 : 32'd0);
            chk("fill_head", 32'(dout8), 32'h01);
        end

        // Overflow: 0x55 is dropped
        cyc8(1'b1, 1'b0, 8'h55, 1'b0);
        chk("ovf_set", 32'(ovf8), 32'd1);
        chk("ovf_level", 32'(lvl8), 32'd8);
        chk("ovf_full", 32'(full8), 32'd1);
        chk("ovf_no_udf", 32'(udf8), 32'd0);

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(dout8), 32'(i));
            cyc8(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain_level", 32'(lvl8), 32'(8 - i));
            chk("drain_ae", 32'(ae8), ((8 - i) <= 2) ? 32'd1 : 32'd0);
            chk("drain_empty", 32'(empty8), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("drain_odata_zero", 32'(dout8), 32'd0);

        // Underflow
        cyc8(1'b0, 1'b1, 8'h00, 1'b0);
        chk("udf_set", 32'(udf8), 32'd1);
        chk("udf_level", 32'(lvl8), 32'd0);
        chk("udf_ovf_sticky", 32'(ovf8), 32'd1);

        cyc8(1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr_ovf", 32'(ovf8), 32'd0);
        chk("clr_udf", 32'(udf8), 32'd0);

        // Empty with read+write: write accepted, read ignored
        cyc8(1'b1, 1'b1, 8'h3C, 1'b0);
        chk("ersw_level", 32'(lvl8), 32'd1);
        chk("ersw_data", 32'(dout8), 32'h3C);
        chk("ersw_udf", 32'(udf8), 32'd1);
        chk("ersw_empty", 32'(empty8), 32'd0);

        // Set and clear in the same cycle: set wins
        cyc8(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pop3c_level", 32'(lvl8), 32'd0);
        cyc8(1'b0, 1'b1, 8'h00, 1'b1);
        chk("setclr_udf", 32'(udf8), 32'd1);
        cyc8(1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr2_udf", 32'(udf8), 32'd0);

        // Full with read+write: 0x10..0x17 then 0xAA
        for (int i = 0; i < 8; i++) begin
            cyc8(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        end
        chk("frsw_pre_full", 32'(full8), 32'd1);
        cyc8(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("frsw_level", 32'(lvl8), 32'd8);
        chk("frsw_ovf", 32'(ovf8), 32'd0);
        chk("frsw_full", 32'(full8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            v = (i == 7) ? 8'hAA : 8'(8'h11 + i);
            chk("frsw_drain", 32'(dout8), 32'(v));
            cyc8(1'b0, 1'b1, 8'h00, 1'b0);
        end
        chk("frsw_empty", 32'(empty8), 32'd1);

        // Wrap on the 5-deep FIFO
        for (int i = 0; i < 3; i++) cyc5(1'b1, 1'b0, 8'(8'h21 + i));
        chk("w5_level3", 32'(lvl5), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("w5_rd_a", 32'(dout5), 32'(8'h21 + i));
            cyc5(1'b0, 1'b1, 8'h00);
        end
        chk("w5_empty", 32'(empty5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc5(1'b1, 1'b0, 8'(8'h31 + i));
            chk("w5_full", 32'(full5), (i == 4) ? 32'd1 : 32'd0);
            chk("w5_af", 32'(af5), (i >= 3) ? 32'd1 : 32'd0);
        end
        chk("w5_level5", 32'(lvl5), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("w5_rd_b", 32'(dout5), 32'(8'h31 + i));
            cyc5(1'b0, 1'b1, 8'h00);
            chk("w5_ae", 32'(ae5), ((4 - i) <= 1) ? 32'd1 : 32'd0);
        end
        chk("w5_end_empty", 32'(empty5), 32'd1);
        chk("w5_no_err", 32'({ovf5, udf5}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
